// File: rtl/cpu_ram_pkg.sv
// Shared constants for the CPU program/data RAM and the encoding of
// which requester currently owns the RAM port.
package cpu_ram_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_BOOT = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares the single-port program/data RAM between the boot loader and the
// CPU control unit: per-cycle req/gnt, round-robin with a burst limit, boot override.
module ram_port_arbiter
    import cpu_ram_pkg::owner_t, cpu_ram_pkg::OWN_NONE, cpu_ram_pkg::OWN_BOOT, cpu_ram_pkg::OWN_CPU;
#(
    parameter int ADDR_W    = cpu_ram_pkg::ADDR_W,
    parameter int DATA_W    = cpu_ram_pkg::DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              boot,
    input  logic              boot_req,
    input  logic              boot_we,
    input  logic [ADDR_W-1:0] boot_adr,
    input  logic [DATA_W-1:0] boot_wdata,
    output logic              boot_gnt,
    output logic              boot_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic              ram_enable,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_in
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BURST);

    owner_t        owner, owner_n;
    owner_t        last_owner, last_owner_n;
    logic [BW-1:0] burst_cnt, burst_cnt_n;
    logic          boot_rvalid_n, cpu_rvalid_n;
    owner_t        winner;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= OWN_NONE;
            last_owner  <= OWN_CPU;
            burst_cnt   <= '0;
            boot_rvalid <= 1'b0;
            cpu_rvalid  <= 1'b0;
        end else begin
            owner       <= owner_n;
            last_owner  <= last_owner_n;
            burst_cnt   <= burst_cnt_n;
            boot_rvalid <= boot_rvalid_n;
            cpu_rvalid  <= cpu_rvalid_n;
        end
    end

    // Grant decision; gated by rst so nothing reaches the RAM while in reset
    always_comb begin
        winner = OWN_NONE;
        if (ce && !rst) begin
            if (boot) begin
                winner = boot_req ? OWN_BOOT : OWN_NONE;
            end else if (boot_req && cpu_req) begin
                if (owner == OWN_NONE)
                    winner = (last_owner == OWN_BOOT) ? OWN_CPU : OWN_BOOT;
                else if (burst_cnt < MAX_CNT)
                    winner = owner;
                else
                    winner = (owner == OWN_BOOT) ? OWN_CPU : OWN_BOOT;
            end else if (boot_req) begin
                winner = OWN_BOOT;
            end else if (cpu_req) begin
                winner = OWN_CPU;
            end
        end
    end

    // Next-state
    always_comb begin
        owner_n       = owner;
        last_owner_n  = last_owner;
        burst_cnt_n   = burst_cnt;
        boot_rvalid_n = boot_rvalid;
        cpu_rvalid_n  = cpu_rvalid;
        if (ce) begin
            boot_rvalid_n = (winner == OWN_BOOT) && !boot_we;
            cpu_rvalid_n  = (winner == OWN_CPU) && !cpu_we;
            if (winner == OWN_NONE) begin
                owner_n     = OWN_NONE;
                burst_cnt_n = '0;
            end else begin
                last_owner_n = winner;
                if (winner == owner) begin
                    burst_cnt_n = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + 1'b1;
                end else begin
                    owner_n     = winner;
                    burst_cnt_n = BW'(1);
                end
            end
        end
    end

    // Outputs: grants and RAM mux
    always_comb begin
        boot_gnt   = (winner == OWN_BOOT);
        cpu_gnt    = (winner == OWN_CPU);
        ram_enable = boot_gnt | cpu_gnt;
        ram_rw     = 1'b0;
        ram_adr    = '0;
        ram_in     = '0;
        if (boot_gnt) begin
            ram_rw  = boot_we;
            ram_adr = boot_adr;
            ram_in  = boot_wdata;
        end else if (cpu_gnt) begin
            ram_rw  = cpu_we;
            ram_adr = cpu_adr;
            ram_in  = cpu_wdata;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed + randomized bench for ram_port_arbiter against a grant-history
// reference model and a shadow copy of RAM contents.
module tb_ram_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst, ce, boot;
    logic          breq, bwe, creq, cwe;
    logic [AW-1:0] badr, cadr;
    logic [DW-1:0] bwd, cwd;
    logic          boot_gnt, boot_rvalid, cpu_gnt, cpu_rvalid;
    logic          ram_enable, ram_rw;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_in;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .ce(ce), .boot(boot),
        .boot_req(breq), .boot_we(bwe), .boot_adr(badr), .boot_wdata(bwd),
        .boot_gnt(boot_gnt), .boot_rvalid(boot_rvalid),
        .cpu_req(creq), .cpu_we(cwe), .cpu_adr(cadr), .cpu_wdata(cwd),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_adr(ram_adr), .ram_in(ram_in)
    );

    // Behavioural single-port RAM with registered read data
    logic [DW-1:0] mem [64];
    logic [DW-1:0] data_out = '0;
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_rw) mem[ram_adr] <= ram_in;
            else        data_out <= mem[ram_adr];
        end
    end

    // Reference model: history of accepted grants (0 idle, 1 boot, 2 cpu)
    int            hist[$];
    bit            exp_brv, exp_crv, rd_known;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] shadow [64];
    bit            written [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int last_nz, tail, streak;
        if (rst || !ce) return 0;
        if (boot) return breq ? 1 : 0;
        if (!(breq && creq)) return breq ? 1 : (creq ? 2 : 0);
        last_nz = 2;
        for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i] != 0) begin last_nz = hist[i]; break; end
        tail = (hist.size() > 0) ? hist[hist.size()-1] : 0;
        if (tail == 0) return (last_nz == 1) ? 2 : 1;
        streak = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != tail) break;
            streak++;
        end
        return (streak < MAXB) ? tail : 3 - tail;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_brv = 0; exp_crv = 0; rd_known = 0;
    endtask

    // One clock: inputs already driven at negedge; check, clock, update model
    task automatic step();
        int eg;
        logic [AW-1:0] a;
        #2;
        eg = model_grant();
        chk("boot_gnt", boot_gnt, eg == 1);
        chk("cpu_gnt", cpu_gnt, eg == 2);
        chk("ram_enable", ram_enable, eg != 0);
        chk("ram_rw", ram_rw, eg == 1 ? bwe : (eg == 2 ? cwe : 1'b0));
        chk("ram_adr", ram_adr, eg == 1 ? badr : (eg == 2 ? cadr : '0));
        chk("ram_in", ram_in, eg == 1 ? bwd : (eg == 2 ? cwd : '0));
        chk("boot_rvalid", boot_rvalid, exp_brv);
        chk("cpu_rvalid", cpu_rvalid, exp_crv);
        if ((exp_brv || exp_crv) && rd_known) chk("rdata", data_out, exp_rdata);
        @(posedge clk);
        if (ce) begin
            hist.push_back(eg);
            exp_brv = (eg == 1) && !bwe;
            exp_crv = (eg == 2) && !cwe;
            if (eg != 0) begin
                a = (eg == 1) ? badr : cadr;
                if ((eg == 1) ? bwe : cwe) begin
                    shadow[a] = (eg == 1) ? bwd : cwd;
                    written[a] = 1;
                end else begin
                    exp_rdata = shadow[a];
                    rd_known = written[a];
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; ce = 1; boot = 0;
        breq = 1; bwe = 0; badr = '0; bwd = '0;
        creq = 1; cwe = 0; cadr = '0; cwd = '0;
        model_reset();
        for (int i = 0; i < 64; i++) written[i] = 0;

        // Reset with both requesting: no grants while in reset
        @(negedge clk); #2;
        chk("rst_boot_gnt", boot_gnt, 0);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ram_enable", ram_enable, 0);
        chk("rst_boot_rvalid", boot_rvalid, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        @(negedge clk);
        rst = 0;
        #1 chk("first_tie_boot", boot_gnt, 1);
        step();
        breq = 0; creq = 0; step();

        // CPU write then read at 0x05; writes never raise rvalid
        creq = 1; cwe = 1; cadr = 6'h05; cwd = 16'hA5A5;
        #1 chk("cpu_wr_gnt", cpu_gnt, 1);
        step();
        cwe = 0;
        #1 chk("cpu_rd_gnt", cpu_gnt, 1);
        chk("wr_no_rvalid", cpu_rvalid, 0);
        step();
        creq = 0;
        #1 chk("cpu_rvalid_next", cpu_rvalid, 1);
        chk("cpu_rdata_a5a5", data_out, 16'hA5A5);
        step();

        // Continuous contention: B,B,B,B,C,C,C,C,...
        breq = 1; creq = 1; bwe = 0; cwe = 0;
        for (int i = 0; i < 16; i++) begin
            #1 chk("burst_pattern_b", boot_gnt, ((i / MAXB) % 2) == 0);
            chk("burst_pattern_c", cpu_gnt, ((i / MAXB) % 2) == 1);
            step();
        end
        breq = 0; creq = 0; step();

        // Boot mode: exclusive boot write to 0x3F, CPU stalls
        boot = 1; creq = 1; cadr = '0;
        breq = 1; bwe = 1; badr = 6'h3F; bwd = 16'h1234;
        #1 chk("bootmode_boot_gnt", boot_gnt, 1);
        chk("bootmode_cpu_stall", cpu_gnt, 0);
        step();
        breq = 0;
        #1 chk("bootmode_cpu_stall2", cpu_gnt, 0);
        step();
        boot = 0; cadr = 6'h3F;
        #1 chk("after_boot_cpu_gnt", cpu_gnt, 1);
        step();
        // Boot rises right after a CPU read: grant drops, rvalid still delivered
        boot = 1;
        #1 chk("boot_rise_cpu_gnt", cpu_gnt, 0);
        chk("boot_rise_cpu_rvalid", cpu_rvalid, 1);
        chk("rdata_1234", data_out, 16'h1234);
        step();
        boot = 0; creq = 0; step();

        // Clock-enable gaps during a CPU read
        creq = 1; cwe = 0; cadr = 6'h05; ce = 1;
        step();
        ce = 0;
        #1 chk("ce0_rvalid", cpu_rvalid, 1);
        chk("ce0_ram_enable", ram_enable, 0);
        step();
        #1 chk("ce0_rvalid_hold", cpu_rvalid, 1);
        step();
        ce = 1; creq = 0;
        #1 chk("ce1_rvalid", cpu_rvalid, 1);
        chk("ce1_rdata", data_out, 16'hA5A5);
        step();
        #1 chk("rvalid_cleared", cpu_rvalid, 0);
        step();

        // Reset right after an accepted boot read discards it
        breq = 1; bwe = 0; badr = 6'h05;
        step();
        #2 rst = 1;
        #1 chk("rst_drop_boot_rvalid", boot_rvalid, 0);
        chk("rst_drop_gnt", boot_gnt | cpu_gnt, 0);
        model_reset();
        @(negedge clk);
        rst = 0; breq = 1; creq = 1;
        #1 chk("post_rst_tie_boot", boot_gnt, 1);
        step();

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            ce   = ($urandom_range(7) != 0);
            if ($urandom_range(19) == 0) boot = ~boot;
            breq = ($urandom_range(9) < 7);
            creq = ($urandom_range(9) < 7);
            bwe  = ($urandom_range(9) < 3);
            cwe  = ($urandom_range(9) < 3);
            badr = AW'($urandom_range(7));
            cadr = AW'($urandom_range(7));
            bwd  = DW'($urandom);
            cwd  = DW'($urandom);
            #1 chk("one_hot_gnt", boot_gnt & cpu_gnt, 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
